demux_1x4_buf: RTL
==================

Name: demux_1x4_buf

Overview:
- Inverse of the 32-bit 4x1 datapath mux: routes one 32-bit input word to one of four output channels, chosen by a 2-bit select.
- Each channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between a single producer, such as the ALU or a memory read-data path, and four destination ports.

Parameters:
- WIDTH, 32, data width of the input word and of each output channel.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- S  input  2  channel select; 00 -> Y0, 01 -> Y1, 10 -> Y2, 11 -> Y3.
- I  input  WIDTH  input data word.
- in_valid  input  1  producer presents I/S this cycle.
- in_ready  output  1  block accepts I/S this cycle.
- Y0, Y1, Y2, Y3  output  WIDTH  channel holding-register contents.
- out_valid  output  4  bit k set: Yk holds an undelivered word.
- out_ready  input  4  bit k set: consumer k takes Yk this cycle.

Behaviour:
- Reset, checked at the clock edge, has priority over everything: out_valid=4'b0000, Y0..Y3=0.
  - Words buffered at a mid-operation reset are discarded.
  - An accept or drain in the reset cycle has no effect.
- in_ready is combinational:
  - in_ready = ~Reset & (~out_valid[S] | out_ready[S]).
  - It depends only on the selected channel. Other channels being full never blocks.
- Accept: in_valid & in_ready at the edge.
  - Y[S] <= I and out_valid[S] <= 1.
  - Latency is 1 cycle: the word appears on Y[S] with out_valid[S]=1 the cycle after acceptance.
- Drain: out_valid[k] & out_ready[k] at the edge, with no accept into channel k -> out_valid[k] <= 0. Yk keeps its last value; it is not cleared.
- Simultaneous drain and accept on the same channel: the old word is delivered, the new word loads, and out_valid[k] stays 1. Full throughput is 1 word per cycle per channel.
- Accept into channel j while a different channel k drains: both happen independently in the same cycle.
- Stall: while out_valid[k]=1 and out_ready[k]=0, Yk and out_valid[k] hold stable. A producer targeting k sees in_ready=0 and must hold I/S/in_valid.
- in_valid=0: no state change except drains.
- out_ready[k] while out_valid[k]=0 is ignored.
- S and I are sampled only when the word is accepted; they are don't-care otherwise.
- No combinational path from I to any Y, or from out_ready to out_valid.
- All four select encodings are valid; there is no out-of-range case.

Decomposition:
- Shared package contents:
  - channel count constant NUM_CH=4.
  - select encodings SEL_CH0..SEL_CH3 (2'b00..2'b11).
  - default data width constant 32, shared with the 4x1 mux.
- Natural sub-module: demux_slot, a one-entry holding register with load/valid/ready logic.
  - Instantiated four times.
  - The top level contains the 2-to-4 select decoder, the in_ready mux and the per-slot load enables.

Test Plan:
- Reset state: assert Reset 2 cycles -> out_valid=0000, Y0..Y3=00000000, in_ready=0 during Reset, in_ready=1 after with S=00.
- Routing sweep, all out_ready=1111: send S=00 I=0000AAAA, S=01 I=AAAA0000, S=10 I=0000FFFF, S=11 I=FFFF0000 on consecutive cycles.
  - Each word appears one cycle later on Y0, Y1, Y2, Y3 respectively, with only the matching out_valid bit set.
  - No other Y changes.
- Per-channel backpressure, out_ready=1101:
  - Send S=01 I=12345678 -> out_valid[1]=1.
  - Next S=01 I=9ABCDEF0 -> in_ready=0 and Y1 holds 12345678.
  - Meanwhile S=10 I=0000FFFF is accepted.
  - Raise out_ready[1] -> 9ABCDEF0 accepted the same cycle and appears next cycle, with out_valid[1] held at 1.
- Simultaneous drain and load: channel 3 full with FFFF0000, out_ready[3]=1, in_valid with S=11 I=DEADBEEF -> in_ready=1; next cycle Y3=DEADBEEF and out_valid[3]=1.
- Drain only: channel 0 full, out_ready=0001, in_valid=0 -> next cycle out_valid[0]=0 and Y0 unchanged.
- Reset mid-operation: fill all four channels with out_ready=0000, then pulse Reset 1 cycle with in_valid=1 S=10 -> out_valid=0000 and Y*=0 after the edge; the presented word is not captured.

Source files
------------

// File: rtl/demux_1x4_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demultiplexer and its sibling 4x1 mux.
package demux_1x4_buf_pkg;

   localparam int NUM_CH     = 4;
   localparam int DATA_WIDTH = 32;

   localparam logic [1:0] SEL_CH0 = 2'b00;
   localparam logic [1:0] SEL_CH1 = 2'b01;
   localparam logic [1:0] SEL_CH2 = 2'b10;
   localparam logic [1:0] SEL_CH3 = 2'b11;

endpackage

// File: rtl/demux_1x4_buf_slot.sv
// One-entry holding register with valid/ready handshake for a single output channel.
module demux_slot
   import demux_1x4_buf_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   // Load wins over drain so a same-cycle drain+load keeps valid high; data is kept after a drain.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1x4_buf.sv
// Routes one input word into one of four buffered output channels chosen by S.
module demux_1x4_buf
   import demux_1x4_buf_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] I,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Y0,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2,
   output logic [WIDTH-1:0] Y3,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready
);

   logic [NUM_CH-1:0] sel_dec;
   logic [NUM_CH-1:0] load;
   logic [WIDTH-1:0]  y_arr [NUM_CH];

   // 2-to-4 select decoder.
   always_comb begin
      sel_dec = '0;
      case (S)
         SEL_CH0: sel_dec[0] = 1'b1;
         SEL_CH1: sel_dec[1] = 1'b1;
         SEL_CH2: sel_dec[2] = 1'b1;
         SEL_CH3: sel_dec[3] = 1'b1;
         default: sel_dec = '0;
      endcase
   end

   // Only the selected channel can stall the producer; a draining slot can take a new word.
   always_comb begin
      in_ready = ~Reset & (~out_valid[S] | out_ready[S]);
      load     = sel_dec & {NUM_CH{in_valid & in_ready}};
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .Clk   (Clk),
         .Reset (Reset),
         .load  (load[k]),
         .d     (I),
         .ready (out_ready[k]),
         .q     (y_arr[k]),
         .valid (out_valid[k])
      );
   end

   assign Y0 = y_arr[0];
   assign Y1 = y_arr[1];
   assign Y2 = y_arr[2];
   assign Y3 = y_arr[3];

endmodule
